// File: rtl/sor_tx.sv
// sor_tx - 8N1 serial transmitter for the debug UART link.
//
// Bytes enter through a one-entry holding register (valid/ready) and are
// serialised on txd: start bit 0, 8 data bits LSB first, stop bit 1, each
// bit lasting CLKS_PER_BIT clocks. A byte queued in the holding register
// while a frame is in flight launches on the stop-end edge, so consecutive
// frames have no idle gap.
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       asynchronous active-high reset
//   tx_data   byte to send, sampled on accept
//   tx_valid  producer offers tx_data
//   tx_ready  holding register empty (accept = tx_valid && tx_ready)
//   txd       registered serial line, idles high
//   tx_busy   a frame is on the line
//   tx_done   one-cycle pulse after each stop bit completes
module sor_tx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state, state_n;
    logic [7:0]    hold, shift, shift_n;
    logic          hold_full, full_clr;
    logic [CW-1:0] cntc, cntc_n;
    logic [2:0]    cntb, cntb_n;
    logic          done_n, txd_n;
    logic          accept;

    assign tx_ready = !hold_full;
    assign tx_busy  = (state != S_IDLE);
    // Launch requires hold_full, which forces tx_ready low, so accept and
    // launch never touch hold on the same edge.
    assign accept   = tx_valid && !hold_full;

    always_comb begin
        state_n  = state;
        shift_n  = shift;
        cntc_n   = cntc;
        cntb_n   = cntb;
        full_clr = 1'b0;
        done_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    shift_n  = hold;
                    full_clr = 1'b1;
                    cntc_n   = RELOAD;
                    state_n  = S_START;
                end
            end
            S_START: begin
                if (cntc == '0) begin
                    cntc_n  = RELOAD;
                    cntb_n  = 3'd0;
                    state_n = S_DATA;
                end else begin
                    cntc_n = cntc - 1'b1;
                end
            end
            S_DATA: begin
                if (cntc == '0) begin
                    shift_n = {1'b0, shift[7:1]};
                    cntc_n  = RELOAD;
                    if (cntb == 3'd7) state_n = S_STOP;
                    else              cntb_n  = cntb + 3'd1;
                end else begin
                    cntc_n = cntc - 1'b1;
                end
            end
            default: begin // S_STOP
                if (cntc == '0) begin
                    done_n = 1'b1;
                    if (hold_full) begin
                        // back-to-back: next start bit begins on this edge
                        shift_n  = hold;
                        full_clr = 1'b1;
                        cntc_n   = RELOAD;
                        state_n  = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cntc_n = cntc - 1'b1;
                end
            end
        endcase
    end

    // txd is registered from the next state so the line level changes on
    // the same edge as the state that owns it.
    always_comb begin
        case (state_n)
            S_START: txd_n = 1'b0;
            S_DATA:  txd_n = shift_n[0];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            shift     <= 8'h00;
            cntc      <= '0;
            cntb      <= 3'd0;
            txd       <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            cntc    <= cntc_n;
            cntb    <= cntb_n;
            txd     <= txd_n;
            tx_done <= done_n;
            if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (full_clr) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sor_tx.sv
// tb_sor_tx - randomized/directed bench for sor_tx with a frame-timeline
// reference model, a mid-bit sampling receiver, and literal spot checks.
module tb_sor_tx;
    localparam int C = 8;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, txd, tx_busy, tx_done;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    int       done_q[$];
    logic [8:0] rx_q[$];

    // reference model: frame timeline position plus a one-entry queue
    bit       m_in, m_full, m_done;
    int       m_t;
    logic [7:0] m_cur, m_hold;

    sor_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_txd();
        int idx;
        if (!m_in) return 1'b1;
        if (m_t < C) return 1'b0;
        if (m_t < 9 * C) begin
            idx = m_t / C - 1;
            return m_cur[idx];
        end
        return 1'b1;
    endfunction

    initial begin
        bit acc;
        logic [7:0] d;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_in = 0; m_full = 0; m_done = 0; m_t = 0; m_cur = 0; m_hold = 0;
            end else begin
                acc    = tx_valid && !m_full;
                d      = tx_data;
                m_done = m_in && (m_t == FRAME - 1);
                if (m_in) begin
                    if (m_t == FRAME - 1) begin
                        if (m_full) begin
                            m_cur = m_hold; m_full = 0; m_t = 0;
                        end else begin
                            m_in = 0;
                        end
                    end else begin
                        m_t++;
                    end
                end else if (m_full) begin
                    m_cur = m_hold; m_full = 0; m_in = 1; m_t = 0;
                end
                if (acc) begin
                    m_hold = d; m_full = 1;
                end
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("txd",      txd,      model_txd());
                chk("tx_busy",  tx_busy,  m_in);
                chk("tx_ready", tx_ready, !m_full);
                chk("tx_done",  tx_done,  m_done);
            end
        end
    end

    always @(negedge clk) if (!rst && tx_done) done_q.push_back(cyc);

    // loopback receiver: samples mid-bit, reports {stop, data}
    initial begin
        logic [8:0] w;
        forever begin
            @(negedge clk);
            if (!rst && txd == 1'b0) begin
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 9; i++) begin
                    repeat (C) @(negedge clk);
                    w[i] = txd;
                end
                rx_q.push_back(w);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // call at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [7:0] b);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_busy(output int l);
        int n = 0;
        while (!tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_rise", tx_busy, 1'b1);
        l = cyc;
    endtask

    task automatic wait_dones(input int cnt);
        int n = 0;
        while (done_q.size() < cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_count", done_q.size(), cnt);
    endtask

    task automatic wait_rx(input int cnt);
        int n = 0;
        while (rx_q.size() < cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rx_count", rx_q.size(), cnt);
    endtask

    initial begin
        int l, bad;
        logic [7:0] rb;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!txd || !tx_ready || tx_busy || tx_done) bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("idle_txd", txd, 1'b1);

        // 0x55: alternating levels, 80-cycle frame
        done_q.delete(); rx_q.delete();
        send(8'h55);
        wait_busy(l);
        for (int k = 0; k < 10; k++) begin
            while (cyc < l + C / 2 + C * k) @(negedge clk);
            chk("bit55", txd, k % 2);
        end
        wait_dones(1);
        if (done_q.size() >= 1) chk("frame_len", done_q[0] - l, FRAME);
        wait_rx(1);
        if (rx_q.size() >= 1) chk("rx55", rx_q[0], 9'h155);
        repeat (5) @(negedge clk);

        // 0xA5 then 0x3C queued mid-frame: back-to-back
        done_q.delete(); rx_q.delete();
        send(8'hA5);
        repeat (20) @(negedge clk);
        send(8'h3C);
        chk("ready_drop", tx_ready, 1'b0);
        wait_dones(2);
        if (done_q.size() >= 2) chk("b2b_gap", done_q[1] - done_q[0], FRAME);
        wait_rx(2);
        if (rx_q.size() >= 2) begin
            chk("rxA5", rx_q[0], 9'h1A5);
            chk("rx3C", rx_q[1], 9'h13C);
        end
        repeat (5) @(negedge clk);

        // reset mid data bit 3 of 0xFF with 0x12 queued
        send(8'hFF);
        wait_busy(l);
        send(8'h12);
        while (cyc < l + 4 * C + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_txd",   txd,      1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy",  tx_busy,  1'b0);
        chk("rst_done",  tx_done,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_q.delete();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (!txd || tx_busy || tx_done) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        chk("post_rst_dones", done_q.size(), 0);

        // stream 0..3 with tx_valid held
        done_q.delete(); rx_q.delete();
        for (int i = 0; i < 4; i++) send(8'(i));
        wait_dones(4);
        if (done_q.size() >= 4)
            for (int i = 0; i < 3; i++) chk("stream_gap", done_q[i+1] - done_q[i], FRAME);
        wait_rx(4);
        if (rx_q.size() >= 4)
            for (int i = 0; i < 4; i++) chk("stream_rx", rx_q[i], 9'h100 | i);
        repeat (5) @(negedge clk);

        // random bytes with random producer gaps
        done_q.delete(); rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            repeat ($urandom_range(0, 90)) @(negedge clk);
            send(rb);
            rx_q.delete();
            wait_rx(1);
            if (rx_q.size() >= 1) chk("rand_rx", rx_q[0], {1'b1, rb});
        end
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
